// File: rtl/grid_port_arbiter_pkg.sv
// Shared types and constants for the map grid read-port arbiter.
// Cell codes, requester IDs, grid dimensions and the return-path tag.
package grid_port_arbiter_pkg;

    localparam int CELL_W = 3;
    localparam int X_W    = 6;
    localparam int Y_W    = 5;
    localparam int ADDR_W = X_W + Y_W;

    localparam int GRID_W_DFLT = 64;
    localparam int GRID_H_DFLT = 32;

    localparam logic [CELL_W-1:0] EMPTY = 3'b000;
    localparam logic [CELL_W-1:0] WALL  = 3'b001;

    localparam logic REQ_PLAYER = 1'b0;
    localparam logic REQ_RAY    = 1'b1;

    // One in-flight read: who asked, and whether it was answered locally
    typedef struct packed {
        logic valid;
        logic owner;
        logic oob;
    } rd_tag_t;

    // Unsigned bounds check at port width against the map dimensions
    function automatic logic in_grid(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y,
        input int             w,
        input int             h
    );
        return (32'(x) < 32'(w)) && (32'(y) < 32'(h));
    endfunction

endpackage

// File: rtl/grid_rd_tag_pipe.sv
// Fixed-depth shift register carrying read tags alongside the memory.
// Async clear drops every in-flight read.
module grid_rd_tag_pipe
    import grid_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clock,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage_q [DEPTH];
    rd_tag_t stage_d [DEPTH];

    // Next stage contents: new tag enters, the rest move one step on
    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/grid_port_arbiter.sv
// Round-robin sharing of the grid memory read port between the player
// logic and the raycaster, with local wall answers for off-map cells.
module grid_port_arbiter
    import grid_port_arbiter_pkg::*;
#(
    parameter int                GRID_W   = GRID_W_DFLT,
    parameter int                GRID_H   = GRID_H_DFLT,
    parameter int                READ_LAT = 1,
    parameter logic [CELL_W-1:0] OOB_CODE = WALL
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [X_W-1:0]    x0,
    input  logic [Y_W-1:0]    y0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [CELL_W-1:0] data0,
    input  logic              req1,
    input  logic [X_W-1:0]    x1,
    input  logic [Y_W-1:0]    y1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [CELL_W-1:0] data1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [CELL_W-1:0] mem_data
);

    logic              last_q, last_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    rd_tag_t           tag_q, tag_d;
    logic [CELL_W-1:0] data0_q, data0_d;
    logic [CELL_W-1:0] data1_q, data1_d;

    logic              pick_any;
    logic              pick_own;
    logic [X_W-1:0]    sel_x;
    logic [Y_W-1:0]    sel_y;
    logic              sel_oob;

    rd_tag_t           tag_out;
    logic [CELL_W-1:0] ret_data;
    logic              rv0;
    logic              rv1;

    // Pick this cycle's winner and build the registered grant/strobe
    always_comb begin
        pick_any = req0 | req1;
        pick_own = (req0 & req1) ? ~last_q : req1;
        sel_x    = (pick_own == REQ_RAY) ? x1 : x0;
        sel_y    = (pick_own == REQ_RAY) ? y1 : y0;
        sel_oob  = !in_grid(sel_x, sel_y, GRID_W, GRID_H);

        gnt0_d     = pick_any & (pick_own == REQ_PLAYER);
        gnt1_d     = pick_any & (pick_own == REQ_RAY);
        mem_rd_d   = pick_any & ~sel_oob;
        mem_addr_d = mem_addr_q;
        if (mem_rd_d) begin
            mem_addr_d = {sel_y, sel_x};
        end
        last_d = pick_any ? pick_own : last_q;

        tag_d.valid = pick_any;
        tag_d.owner = pick_own;
        tag_d.oob   = sel_oob;
    end

    // Grant-cycle registers; pointer starts at 1 so player wins first tie
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q     <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            tag_q      <= '0;
        end else begin
            last_q     <= last_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            tag_q      <= tag_d;
        end
    end

    // Tag leaves the pipe in the same cycle the memory data appears
    grid_rd_tag_pipe #(
        .DEPTH (READ_LAT)
    ) u_tag_pipe (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (tag_q),
        .tag_out (tag_out)
    );

    // Steer returning data to its owner, holding the last value otherwise
    always_comb begin
        ret_data = tag_out.oob ? OOB_CODE : mem_data;
        rv0      = tag_out.valid & (tag_out.owner == REQ_PLAYER);
        rv1      = tag_out.valid & (tag_out.owner == REQ_RAY);
        data0_d  = rv0 ? ret_data : data0_q;
        data1_d  = rv1 ? ret_data : data1_q;
    end

    // Per-requester data hold registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign rvalid0  = rv0;
    assign rvalid1  = rv1;
    assign data0    = data0_d;
    assign data1    = data1_d;

endmodule

// File: tb/tb_grid_port_arbiter.sv
// Bench for grid_port_arbiter: three configurations share one stimulus,
// each with a latency-accurate memory and a queue-based reference model.
module tb_grid_port_arbiter;
    import grid_port_arbiter_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0  = 1'b0;
    logic       req1  = 1'b0;
    logic [5:0] x0    = '0;
    logic [5:0] x1    = '0;
    logic [4:0] y0    = '0;
    logic [4:0] y1    = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         own;
        bit         oob;
        logic [10:0] a;
    } ev_t;

    // Memory contents: address-derived pattern, with 0x0C5 holding EMPTY
    function automatic logic [2:0] cell_of(input logic [10:0] a);
        if (a == 11'h0C5) return EMPTY;
        return a[2:0] ^ a[5:3] ^ a[8:6] ^ {1'b0, a[10:9]};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int L = (g == 1) ? 3 : (g == 2) ? 2 : 1;
        localparam int W = (g == 1) ? 40 : (g == 2) ? 48 : 64;
        localparam int H = (g == 1) ? 20 : (g == 2) ? 24 : 32;

        logic        gnt0, gnt1, rvalid0, rvalid1, mem_rd;
        logic [2:0]  data0, data1;
        logic [2:0]  mem_data = '0;
        logic [10:0] mem_addr;

        grid_port_arbiter #(
            .GRID_W   (W),
            .GRID_H   (H),
            .READ_LAT (L),
            .OOB_CODE (WALL)
        ) u_dut (
            .clock    (clk),
            .reset    (rst_n),
            .req0     (req0),
            .x0       (x0),
            .y0       (y0),
            .gnt0     (gnt0),
            .rvalid0  (rvalid0),
            .data0    (data0),
            .req1     (req1),
            .x1       (x1),
            .y1       (y1),
            .gnt1     (gnt1),
            .rvalid1  (rvalid1),
            .data1    (data1),
            .mem_addr (mem_addr),
            .mem_rd   (mem_rd),
            .mem_data (mem_data)
        );

        // Grid memory with L cycles of read latency; garbage when idle
        logic [11:0] mp [L];
        initial begin
            for (int k = 0; k < L; k++) mp[k] = '0;
            forever begin
                @(posedge clk);
                for (int k = L - 1; k > 0; k--) mp[k] = mp[k-1];
                mp[0] = {mem_rd, mem_addr};
                mem_data <= mp[L-1][11] ? cell_of(mp[L-1][10:0])
                                        : 3'($urandom);
            end
        end

        // Reference: per-cycle winner, and a schedule of expected returns
        ev_t         q[$];
        int          last = 1;
        int          cyc  = 0;
        bit          eg0 = 0, eg1 = 0, erd = 0, ev0 = 0, ev1 = 0;
        logic [10:0] eaddr = '0;
        logic [2:0]  ed0 = '0, ed1 = '0;

        initial begin
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    q.delete();
                    last = 1;
                    eg0 = 0; eg1 = 0; erd = 0; ev0 = 0; ev1 = 0;
                    ed0 = '0; ed1 = '0;
                end else begin : upd
                    int         w;
                    logic [5:0] xx;
                    logic [4:0] yy;
                    bit         oob;
                    ev_t        e;
                    cyc++;
                    w = -1;
                    if (req0 && req1) w = (last == 1) ? 0 : 1;
                    else if (req0)    w = 0;
                    else if (req1)    w = 1;
                    eg0 = (w == 0);
                    eg1 = (w == 1);
                    erd = 0;
                    if (w >= 0) begin
                        xx  = (w == 1) ? x1 : x0;
                        yy  = (w == 1) ? y1 : y0;
                        oob = (int'(xx) >= W) || (int'(yy) >= H);
                        erd = !oob;
                        if (!oob) eaddr = {yy, xx};
                        last = w;
                        e.cyc = cyc + L;
                        e.own = (w == 1);
                        e.oob = oob;
                        e.a   = {yy, xx};
                        q.push_back(e);
                    end
                    ev0 = 0;
                    ev1 = 0;
                    if (q.size() > 0 && q[0].cyc == cyc) begin
                        e = q.pop_front();
                        if (e.own) begin
                            ev1 = 1;
                            ed1 = e.oob ? WALL : cell_of(e.a);
                        end else begin
                            ev0 = 1;
                            ed0 = e.oob ? WALL : cell_of(e.a);
                        end
                    end
                end
            end
        end

        // Compare every output against the model mid-cycle
        initial begin
            forever begin
                @(negedge clk);
                chk($sformatf("c%0d gnt0", g), int'(gnt0), int'(eg0));
                chk($sformatf("c%0d gnt1", g), int'(gnt1), int'(eg1));
                chk($sformatf("c%0d mem_rd", g), int'(mem_rd), int'(erd));
                if (erd)
                    chk($sformatf("c%0d mem_addr", g),
                        int'(mem_addr), int'(eaddr));
                chk($sformatf("c%0d rvalid0", g), int'(rvalid0), int'(ev0));
                chk($sformatf("c%0d rvalid1", g), int'(rvalid1), int'(ev1));
                chk($sformatf("c%0d data0", g), int'(data0), int'(ed0));
                chk($sformatf("c%0d data1", g), int'(data1), int'(ed1));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst gnt0", int'(g_cfg[0].gnt0), 0);
        chk("rst mem_rd", int'(g_cfg[0].mem_rd), 0);
        chk("rst mem_addr", int'(g_cfg[0].mem_addr), 0);
        chk("rst data1", int'(g_cfg[0].data1), 0);
        do_reset();

        // Single player read of cell (5,3)
        req0 = 1'b1; x0 = 6'd5; y0 = 5'd3;
        tick();
        chk("single gnt0", int'(g_cfg[0].gnt0), 1);
        chk("single gnt1", int'(g_cfg[0].gnt1), 0);
        chk("single mem_rd", int'(g_cfg[0].mem_rd), 1);
        chk("single addr", int'(g_cfg[0].mem_addr), 'h0C5);
        req0 = 1'b0;
        tick();
        chk("single rvalid0", int'(g_cfg[0].rvalid0), 1);
        chk("single data0", int'(g_cfg[0].data0), 0);
        chk("single rvalid1", int'(g_cfg[0].rvalid1), 0);
        repeat (4) tick();

        // Both held from reset: grants alternate starting with player
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            x0 = 6'($urandom); y0 = 5'($urandom);
            x1 = 6'($urandom); y1 = 5'($urandom);
            tick();
            chk("alt gnt0", int'(g_cfg[1].gnt0), int'(k % 2 == 0));
            chk("alt gnt1", int'(g_cfg[1].gnt1), int'(k % 2 == 1));
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (5) tick();

        // Off-map x for the 40-wide configuration
        do_reset();
        req1 = 1'b1; x1 = 6'd45; y1 = 5'd2;
        tick();
        chk("oob gnt1", int'(g_cfg[1].gnt1), 1);
        chk("oob mem_rd", int'(g_cfg[1].mem_rd), 0);
        chk("inrange mem_rd", int'(g_cfg[0].mem_rd), 1);
        req1 = 1'b0;
        repeat (3) tick();
        chk("oob rvalid1", int'(g_cfg[1].rvalid1), 1);
        chk("oob data1", int'(g_cfg[1].data1), int'(WALL));
        repeat (3) tick();

        // Reset one cycle after a grant drops the in-flight read
        do_reset();
        req0 = 1'b1; x0 = 6'd7; y0 = 5'd4;
        tick();
        req0 = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid gnt0", int'(g_cfg[2].gnt0), 0);
        chk("mid rvalid0", int'(g_cfg[2].rvalid0), 0);
        chk("mid mem_rd", int'(g_cfg[2].mem_rd), 0);
        chk("mid data0", int'(g_cfg[2].data0), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post rvalid0", int'(g_cfg[1].rvalid0), 0);
        req0 = 1'b1; req1 = 1'b1;
        tick();
        chk("post tie gnt0", int'(g_cfg[2].gnt0), 1);
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) tick();

        // Withdrawn player request while raycaster wins the tie
        do_reset();
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        tick();
        req0 = 1'b1; req1 = 1'b1;
        tick();
        chk("drop tie gnt1", int'(g_cfg[0].gnt1), 1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("drop gnt0", int'(g_cfg[0].gnt0), 0);
        repeat (4) tick();

        // Random traffic with occasional asynchronous resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req0 = ($urandom_range(3) != 0);
            req1 = ($urandom_range(2) != 0);
            x0 = 6'($urandom); y0 = 5'($urandom);
            x1 = 6'($urandom); y1 = 5'($urandom);
            if ($urandom_range(400) == 0) begin
                #2;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grid_port_arbiter.md
Name: grid_port_arbiter

Overview:
- Shares the single read port of the map grid memory between two requesters: requester 0 (player movement/collision check) and requester 1 (raycaster wall lookup).
- Round-robin arbitration with one grant per cycle and a fixed-latency return path tagged per requester.
- Out-of-map coordinates are answered locally with a wall code and never reach memory.
- Sits between the player update logic, the raycaster and the grid RAM/ROM.

Parameters:
- GRID_W, 64, map width in cells; valid x is 0..GRID_W-1.
- GRID_H, 32, map height in cells; valid y is 0..GRID_H-1.
- READ_LAT, 1, grid memory read latency in cycles (1..3).
- OOB_CODE, 3'b001, cell type returned for out-of-range coordinates.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req0  in  1  requester 0 read request, level
- x0  in  6  requester 0 grid x
- y0  in  5  requester 0 grid y
- gnt0  out  1  one-cycle grant pulse to requester 0
- rvalid0  out  1  one-cycle pulse; data0 valid
- data0  out  3  cell type for requester 0
- req1, x1, y1, gnt1, rvalid1, data1  same as above, for requester 1
- mem_addr  out  11  grid memory address, {y,x}
- mem_rd  out  1  read strobe to grid memory
- mem_data  in  3  grid memory read data, valid READ_LAT cycles after mem_rd

Behaviour:
- Reset (reset=0, asynchronous): gnt*, rvalid*, data*, mem_rd = 0; mem_addr = 0; last-grant pointer = 1, so requester 0 wins the first tie; the return pipeline is cleared.
- Reset mid-operation: in-flight reads are dropped and produce no rvalid after reset releases.
- Handshake:
  - A requester holds req and its x/y stable until it samples gnt=1.
  - gnt is registered: it asserts the cycle after the arbiter samples req.
  - A requester keeping req high after gnt issues a new request.
  - At most one gnt per cycle across both requesters.
- Arbitration:
  - If only one requester is pending, it is granted.
  - If both are pending, grant the requester that was not granted last; the pointer updates on every grant.
  - A requester with req held continuously is granted within 2 cycles.
- Grant cycle:
  - In-range coordinates (x<GRID_W and y<GRID_H): mem_rd=1 and mem_addr={y,x} in the same cycle as gnt.
  - Out-of-range coordinates: mem_rd stays 0, and the tag records OOB.
- Return pipeline:
  - A shift register of depth READ_LAT carries {valid, owner, oob}.
  - Exactly READ_LAT cycles after gnt, rvalid of the owner pulses for 1 cycle.
  - dataN = OOB_CODE if the oob tag is set, else mem_data.
- Data hold: dataN holds its last value between rvalid pulses.
- Throughput: one access per cycle; back-to-back grants alternate when both requesters are pending.
- The pipeline is fully pipelined, so there is no stall.
- Drop rule: req deasserted before gnt withdraws the request and no gnt is issued. req sampled low means no grant that cycle.
- Width rules:
  - Address is a pure concatenation; no multiply.
  - Comparisons are unsigned at port widths.
  - With default parameters y<32 and x<64 are always in range; the OOB path matters only for smaller GRID_W/GRID_H.

Decomposition:
- Shared package:
  - Cell-type constants: EMPTY=3'b000, WALL=3'b001.
  - Requester IDs: REQ_PLAYER=0, REQ_RAY=1.
  - Grid dimension constants.
- One sub-module: grid_rd_tag_pipe, a parameterised READ_LAT-deep shift register of {valid, owner, oob} with async active-low clear.

Test Plan:
- Single requester 0, x0=5, y0=3, mem returns 3'b000 for addr {3,5}=0x0C5 → gnt0 one cycle after req0, mem_rd with mem_addr=0x0C5, rvalid0 READ_LAT cycles later, data0=0; no gnt1 or rvalid1.
- Both req0 and req1 held 6 cycles from reset → grants alternate 0,1,0,1…; each rvalid carries its own cell (addr-derived pattern in the memory model).
- GRID_W=40, req1 with x1=45 → gnt1, mem_rd=0, rvalid1 after READ_LAT with data1=3'b001.
- READ_LAT=3, back-to-back requests from both requesters → 3 in flight; rvalids arrive in grant order with correct owner and data.
- Assert reset low one cycle after a grant with READ_LAT=2 → all outputs 0 immediately; no rvalid after reset release; first tie after release goes to requester 0.
- req0 pulsed for one cycle while requester 1 wins the tie → req0 dropped; no gnt0 and no rvalid0.
